// File: rtl/bt_seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// bt_pkg : shared types and trit helpers for the balanced-ternary multiplier.
//
// Trit encoding (two bits per trit):
//   2'b10 = +1, 2'b01 = -1, 2'b11 = 0, 2'b00 = illegal (read as 0).
//
// Contents:
//   trit_t                       one encoded trit
//   TRIT_POS/TRIT_NEG/TRIT_ZERO  encoded constants
//   state_t                      multiplier FSM states
//   trit_val / trit_enc          encoded trit <-> small integer
//   trit_neg                     negate one trit
//   trit_mul                     product of two trits
//   trit_fa                      balanced full adder, returns {carry, sum}
// ---------------------------------------------------------------------------
package bt_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_POS  = 2'b10;
    localparam trit_t TRIT_NEG  = 2'b01;
    localparam trit_t TRIT_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Anything that is not +1 or -1 (including the illegal 2'b00) decodes to 0.
    function automatic int trit_val(input trit_t t);
        case (t)
            TRIT_POS: return 1;
            TRIT_NEG: return -1;
            default:  return 0;
        endcase
    endfunction

    function automatic trit_t trit_enc(input int v);
        if (v > 0)
            return TRIT_POS;
        else if (v < 0)
            return TRIT_NEG;
        else
            return TRIT_ZERO;
    endfunction

    function automatic trit_t trit_neg(input trit_t t);
        return trit_enc(-trit_val(t));
    endfunction

    // Re-encoding through trit_val also normalises 2'b00 to 2'b11.
    function automatic trit_t trit_mul(input trit_t a, input trit_t b);
        case (b)
            TRIT_POS: return trit_enc(trit_val(a));
            TRIT_NEG: return trit_neg(a);
            default:  return TRIT_ZERO;
        endcase
    endfunction

    // s = a+b+c lies in -3..3; carry absorbs +-3 so the sum digit stays in -1..1.
    function automatic logic [3:0] trit_fa(input trit_t a, input trit_t b, input trit_t c);
        int s;
        s = trit_val(a) + trit_val(b) + trit_val(c);
        if (s > 1)
            return {TRIT_POS, trit_enc(s - 3)};
        else if (s < -1)
            return {TRIT_NEG, trit_enc(s + 3)};
        else
            return {TRIT_ZERO, trit_enc(s)};
    endfunction

endpackage

// File: rtl/bt_seq_mul_if.sv
// ---------------------------------------------------------------------------
// bt_seq_mul_if : operand/result handshake bundle for bt_seq_mul.
//
// Signals (trit i of every vector at [2i+1:2i]):
//   in_valid   master->slave  operands x,y presented
//   in_ready   slave->master  multiplier can accept operands
//   x, y       master->slave  multiplicand / multiplier, N_TRITS trits each
//   out_valid  slave->master  prod valid
//   out_ready  master->slave  consumer accepts prod
//   prod       slave->master  2*N_TRITS-trit product
//   busy       slave->master  multiplier not idle
//   err        slave->master  illegal-trit flag, present only when
//                             BT_INVALID_CHECK_EN is defined
// ---------------------------------------------------------------------------
interface bt_seq_mul_if #(
    parameter int N_TRITS = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [2*N_TRITS-1:0]   x;
    logic [2*N_TRITS-1:0]   y;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*N_TRITS-1:0]   prod;
    logic                   busy;
`ifdef BT_INVALID_CHECK_EN
    logic                   err;
`endif

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, prod, busy
`ifdef BT_INVALID_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, prod, busy
`ifdef BT_INVALID_CHECK_EN
        , output err
`endif
    );

endinterface

// File: rtl/bt_seq_mul_add.sv
// ---------------------------------------------------------------------------
// bt_add : combinational ripple-carry balanced-ternary adder.
//
// Ports (trit i at [2i+1:2i]):
//   i_a, i_b   in   2*N_TRITS  addends
//   o_sum      out  2*N_TRITS  a + b, truncated to N_TRITS trits
//   o_carry    out  2          carry out of the top trit
// ---------------------------------------------------------------------------
module bt_add
    import bt_pkg::*;
#(
    parameter int N_TRITS = 8
) (
    input  logic [2*N_TRITS-1:0] i_a,
    input  logic [2*N_TRITS-1:0] i_b,
    output logic [2*N_TRITS-1:0] o_sum,
    output trit_t                o_carry
);

    trit_t w_carry [N_TRITS+1];

    assign w_carry[0] = TRIT_ZERO;

    generate
        for (genvar gi = 0; gi < N_TRITS; gi++) begin : g_stage
            logic [3:0] w_fa;
            assign w_fa            = trit_fa(i_a[2*gi +: 2], i_b[2*gi +: 2], w_carry[gi]);
            assign o_sum[2*gi +: 2] = w_fa[1:0];
            assign w_carry[gi+1]   = w_fa[3:2];
        end
    endgenerate

    assign o_carry = w_carry[N_TRITS];

endmodule

// File: rtl/bt_seq_mul.sv
// ---------------------------------------------------------------------------
// bt_seq_mul : sequential balanced-ternary multiplier, N_TRITS x N_TRITS ->
// 2*N_TRITS trits. Shift-add: one multiplier trit is consumed per cycle.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   bus     slave modport of bt_seq_mul_if (in_valid/in_ready/x/y,
//           out_valid/out_ready/prod, busy, and err when enabled)
//
// Optional feature macro: BT_INVALID_CHECK_EN
//   When defined, err reports that the operands of the current result
//   contained an illegal 2'b00 trit. When undefined there is no err and no
//   extra state.
//
// Timing: IDLE (accept) -> N_TRITS RUN cycles -> DONE (held until out_ready).
// ---------------------------------------------------------------------------
module bt_seq_mul
    import bt_pkg::*;
#(
    parameter int N_TRITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bt_seq_mul_if.slave   bus
);

    localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
    localparam int P_W   = 4 * N_TRITS;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*N_TRITS-1:0] r_x;
    logic [2*N_TRITS-1:0] r_y;
    logic [P_W-1:0]       r_acc;

    logic                 w_in_ready;
    logic                 w_accept;
    trit_t                w_ytrit;
    logic [P_W-1:0]       w_pp_base;
    logic [P_W-1:0]       w_pp;
    logic [P_W-1:0]       w_sum;
    trit_t                w_carry_unused;

    // ---------------- FSM ----------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = rst_n;
                if (bus.in_valid && rst_n)
                    w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(N_TRITS - 1))
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    // ---------------- partial product ----------------
    assign w_ytrit = r_y[{r_cnt, 1'b0} +: 2];

    generate
        for (genvar gi = 0; gi < N_TRITS; gi++) begin : g_pp
            assign w_pp_base[2*gi +: 2] = trit_mul(r_x[2*gi +: 2], w_ytrit);
        end
    endgenerate
    assign w_pp_base[P_W-1:2*N_TRITS] = {N_TRITS{TRIT_ZERO}};

    // A plain shift would fill with 2'b00; shifting the inverted vector and
    // inverting back fills the vacated low trits with the proper zero 2'b11.
    assign w_pp = ~((~w_pp_base) << {r_cnt, 1'b0});

    // The top carry is provably zero (the product always fits in 2N trits).
    bt_add #(.N_TRITS(2*N_TRITS)) u_add (
        .i_a     (r_acc),
        .i_b     (w_pp),
        .o_sum   (w_sum),
        .o_carry (w_carry_unused)
    );

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= {(2*N_TRITS){TRIT_ZERO}};
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= {(2*N_TRITS){TRIT_ZERO}};
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operands are captured only on the accept cycle; no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x <= bus.x;
            r_y <= bus.y;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.prod      = r_acc;
    assign bus.busy      = (r_state != ST_IDLE);

`ifdef BT_INVALID_CHECK_EN
    logic                 r_err_pend;
    logic [N_TRITS-1:0]   w_trit_bad;

    generate
        for (genvar gi = 0; gi < N_TRITS; gi++) begin : g_bad
            assign w_trit_bad[gi] = (bus.x[2*gi +: 2] == 2'b00) ||
                                    (bus.y[2*gi +: 2] == 2'b00);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err_pend <= 1'b0;
        else if (w_accept)
            r_err_pend <= |w_trit_bad;
    end

    assign bus.err = r_err_pend && (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_bt_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_bt_seq_mul : directed bench for bt_seq_mul with N_TRITS = 4.
// Encoded constants below are MS trit first, two bits per trit
// (10=+1, 01=-1, 11=0), e.g. 40 = "++++" = 8'hAA.
// ---------------------------------------------------------------------------
module tb_bt_seq_mul;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    bt_seq_mul_if #(.N_TRITS(N)) bus ();

    bt_seq_mul #(.N_TRITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Integer -> 8-trit balanced-ternary encoding (reference model).
    function automatic logic [15:0] to_bt(input int v);
        logic [15:0] r;
        int q, m;
        r = '1;
        q = v;
        for (int i = 0; i < 8; i++) begin
            m = ((q % 3) + 3) % 3;
            if (m == 0) begin
                r[2*i +: 2] = 2'b11; q = q / 3;
            end else if (m == 1) begin
                r[2*i +: 2] = 2'b10; q = (q - 1) / 3;
            end else begin
                r[2*i +: 2] = 2'b01; q = (q + 1) / 3;
            end
        end
        return r;
    endfunction

    // One operation with out_ready high. lat counts the accept cycle plus
    // every cycle until out_valid is seen.
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv,
                          output logic [15:0] p, output int lat, output logic e);
        int n;
        bus.x = xv;
        bus.y = yv;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.x = ~xv;
        bus.y = ~yv;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        p = bus.prod;
`ifdef BT_INVALID_CHECK_EN
        e = bus.err;
`else
        e = 1'b0;
`endif
        tick();
        $display("op x=%h y=%h prod=%h lat=%0d", xv, yv, p, lat);
    endtask

    logic [15:0] p, p_hold, tmp_a, tmp_b;
    int          lat, n;
    logic        e, seen;
    realtime     t_prev;
    logic [7:0]  b2b_x [3] = '{8'hAA, 8'h55, 8'hE5};
    logic [7:0]  b2b_y [3] = '{8'hAA, 8'hAA, 8'hD9};
    logic [15:0] b2b_p [3] = '{16'h9966, 16'h6699, 16'hFF5E};

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.x         = '1;
        bus.y         = '1;
        tick(); tick(); tick();

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_prod", 32'(bus.prod), 32'h0000FFFF);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        $display("reset checked");

        // 40*40 = 1600, latency
        run_op(8'hAA, 8'hAA, p, lat, e);
        check("p40x40", 32'(p), 32'h00009966);
        check("latency", 32'(lat), 32'(N + 1));
        check("idle_after", 32'(bus.busy), 32'd0);
        // -40*40 = -1600
        run_op(8'h55, 8'hAA, p, lat, e);
        check("pm40x40", 32'(p), 32'h00006699);
        // zero operands
        run_op(8'hFF, 8'hD5, p, lat, e);
        check("p0xa", 32'(p), 32'h0000FFFF);
        run_op(8'hD5, 8'hFF, p, lat, e);
        check("pax0", 32'(p), 32'h0000FFFF);
        // 1 * -13
        run_op(8'hFE, 8'hD5, p, lat, e);
        check("p1xm13", 32'(p), 32'h0000FFD5);

        // Back-pressure: hold out_ready low 10 cycles in DONE, in_valid high
        bus.out_ready = 1'b0;
        bus.x = 8'hAA;
        bus.y = 8'h55;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        tick();
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("bp_valid_start", 32'(bus.out_valid), 32'd1);
        p_hold = bus.prod;
        check("bp_prod_start", 32'(p_hold), 32'h00006699);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_prod", 32'(bus.prod), 32'h00006699);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_ready", 32'(bus.in_ready), 32'd1);
        $display("backpressure op prod=%h", p_hold);

        // Reset mid-op at cnt=2
        bus.x = 8'hAA;
        bus.y = 8'hAA;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_prod", 32'(bus.prod), 32'h0000FFFF);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_op(8'hE5, 8'hD9, p, lat, e);
        check("p5xm7", 32'(p), 32'h0000FF5E);

        // Back-to-back with in_valid held high
        bus.in_valid = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            bus.x = b2b_x[i];
            bus.y = b2b_y[i];
            n = 0;
            while (!bus.in_ready && n < 20) begin tick(); n++; end
            check("b2b_ready", 32'(bus.in_ready), 32'd1);
            tick();
            if (i > 0)
                check("b2b_spacing", 32'(int'(($realtime - t_prev) / 10.0)), 32'(N + 2));
            t_prev = $realtime;
            n = 0;
            while (!bus.out_valid && n < 20) begin tick(); n++; end
            check("b2b_prod", 32'(bus.prod), 32'(b2b_p[i]));
            check("b2b_in_ready_done", 32'(bus.in_ready), 32'd0);
            $display("b2b op %0d x=%h y=%h prod=%h", i, b2b_x[i], b2b_y[i], bus.prod);
        end
        bus.in_valid = 1'b0;
        tick(); tick();

`ifdef BT_INVALID_CHECK_EN
        // x = "+00" with illegal LS trit -> treated as 27
        run_op(8'hBC, 8'hFE, p, lat, e);
        check("err_set", 32'(e), 32'd1);
        check("err_prod", 32'(p), 32'h0000FFBF);
        run_op(8'hAA, 8'hFE, p, lat, e);
        check("err_clear", 32'(e), 32'd0);
        check("err_clear_prod", 32'(p), 32'h0000FFAA);
`endif

        // Full sweep of legal operand pairs against the integer model
        for (int a = -40; a <= 40; a++) begin
            for (int b = -40; b <= 40; b++) begin
                tmp_a = to_bt(a);
                tmp_b = to_bt(b);
                run_op(tmp_a[7:0], tmp_b[7:0], p, lat, e);
                check("sweep", 32'(p), 32'(to_bt(a * b)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
